dct_basis_gen: RTL

DCT_BASIS_GEN -- requirements
Module: dct_basis_gen

---
 rtl/dct_pkg.sv | 51 +++++
 rtl/dct_cos_rom.sv | 27 ++
 rtl/dct_basis_gen.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/dct_pkg.sv
// Shared types, default sizing and the elaboration-time cosine helper for the DCT basis
// generator.
package dct_pkg;

    localparam int unsigned DefaultN     = 8;
    localparam int unsigned DefaultFrac  = 8;
    localparam int unsigned DefaultIw    = $clog2(DefaultN);
    localparam int unsigned DefaultCosW  = DefaultFrac + 2;
    localparam int unsigned DefaultProdW = 2 * DefaultFrac + 4;

    localparam real Pi = 3.14159265358979323846;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } dct_state_e;

    // round-half-away(cos((2n+1)*k*pi/(2*nn)) * 2^frac). The angle is folded into the first
    // quadrant so the Taylor series converges quickly, and the rounding works on a magnitude.
    function automatic int cos_fixed(input int k, input int n, input int nn, input int frac);
        real x;
        real term;
        real sum;
        real v;
        int  m;
        int  sgn;
        m = ((2 * n + 1) * k) % (4 * nn);
        if (m > 2 * nn) begin
            m = 4 * nn - m;
        end
        sgn = 1;
        if (m > nn) begin
            sgn = -1;
            m   = 2 * nn - m;
        end
        x    = real'(m) * Pi / real'(2 * nn);
        sum  = 1.0;
        term = 1.0;
        for (int i = 1; i <= 12; i++) begin
            term = -term * x * x / real'((2 * i - 1) * (2 * i));
            sum  = sum + term;
        end
        v = sum;
        for (int i = 0; i < frac; i++) begin
            v = v * 2.0;
        end
        return sgn * $rtoi(v + 0.5);
    endfunction

endpackage

// File: rtl/dct_cos_rom.sv
// Cosine lookup C(k,n) for an N-point DCT; the table is built at elaboration from cos_fixed.
module dct_cos_rom
    import dct_pkg::*;
#(
    parameter int unsigned N    = DefaultN,
    parameter int unsigned FRAC = DefaultFrac
) (
    input  logic [$clog2(N)-1:0] k_i,
    input  logic [$clog2(N)-1:0] n_i,
    output logic signed [FRAC+1:0] cos_o
);

    localparam int unsigned CosW = FRAC + 2;

    logic signed [CosW-1:0] rom_tbl [N*N];

    for (genvar gk = 0; gk < N; gk++) begin : g_k
        for (genvar gn = 0; gn < N; gn++) begin : g_n
            localparam int CosVal = cos_fixed(gk, gn, N, FRAC);
            assign rom_tbl[gk*N+gn] = CosW'(CosVal);
        end
    end

    // N is a power of two, so {k,n} is exactly the row-major table index.
    assign cos_o = rom_tbl[{k_i, n_i}];

endmodule

// File: rtl/dct_basis_gen.sv
// Streams the N*N terms C(k1,n1)*C(k2,n2) of one 2-D DCT basis image through a three-stage
// pipeline (index counter, cosine read, product) with valid/ready backpressure.
module dct_basis_gen
    import dct_pkg::*;
#(
    parameter int unsigned N     = DefaultN,
    parameter int unsigned FRAC  = DefaultFrac,
    parameter int unsigned OUT_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [$clog2(N)-1:0]    req_k1,
    input  logic [$clog2(N)-1:0]    req_k2,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(N)-1:0]    out_n1,
    output logic [$clog2(N)-1:0]    out_n2,
    output logic signed [OUT_W-1:0] out_term,
    output logic                    out_last
);

    localparam int unsigned Iw    = $clog2(N);
    localparam int unsigned CosW  = FRAC + 2;
    localparam int unsigned ProdW = 2 * FRAC + 4;
    localparam logic [Iw-1:0] IdxMax = Iw'(N - 1);

    dct_state_e state_q;
    logic [Iw-1:0] k1_q, k2_q;
    logic [Iw-1:0] cnt_n1_q, cnt_n2_q;

    logic          s1_valid_q;
    logic [Iw-1:0] s1_n1_q, s1_n2_q;

    logic                   s2_valid_q, s2_last_q;
    logic [Iw-1:0]          s2_n1_q, s2_n2_q;
    logic signed [CosW-1:0] s2_c1_q, s2_c2_q;

    logic                    out_valid_q, out_last_q;
    logic [Iw-1:0]           out_n1_q, out_n2_q;
    logic signed [OUT_W-1:0] out_term_q;

    logic signed [CosW-1:0]  rom_c1, rom_c2;
    logic signed [ProdW-1:0] prod;
    logic        [ProdW-1:0] prod_mag;
    logic signed [ProdW-1:0] term_full;

    logic accept;
    logic advance;
    logic issue_last;
    logic last_hs;

    assign req_ready  = (state_q == StIdle);
    assign accept     = req_valid && req_ready;
    // A presented term that is not taken freezes every stage, including the counter.
    assign advance    = !(out_valid_q && !out_ready);
    assign issue_last = (cnt_n1_q == IdxMax) && (cnt_n2_q == IdxMax);
    assign last_hs    = out_valid_q && out_ready && out_last_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            k1_q     <= '0;
            k2_q     <= '0;
            cnt_n1_q <= '0;
            cnt_n2_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q  <= StRun;
                        k1_q     <= req_k1;
                        k2_q     <= req_k2;
                        cnt_n1_q <= '0;
                        cnt_n2_q <= '0;
                    end
                end
                StRun: begin
                    if (advance) begin
                        cnt_n2_q <= cnt_n2_q + 1'b1;
                        if (cnt_n2_q == IdxMax) begin
                            cnt_n1_q <= cnt_n1_q + 1'b1;
                        end
                        if (issue_last) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (last_hs) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_n1_q    <= '0;
            s1_n2_q    <= '0;
        end else if (advance) begin
            s1_valid_q <= (state_q == StRun);
            s1_n1_q    <= cnt_n1_q;
            s1_n2_q    <= cnt_n2_q;
        end
    end

    dct_cos_rom #(
        .N    (N),
        .FRAC (FRAC)
    ) u_rom_k1 (
        .k_i   (k1_q),
        .n_i   (s1_n1_q),
        .cos_o (rom_c1)
    );

    dct_cos_rom #(
        .N    (N),
        .FRAC (FRAC)
    ) u_rom_k2 (
        .k_i   (k2_q),
        .n_i   (s1_n2_q),
        .cos_o (rom_c2)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_n1_q    <= '0;
            s2_n2_q    <= '0;
            s2_c1_q    <= '0;
            s2_c2_q    <= '0;
        end else if (advance) begin
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_valid_q && (s1_n1_q == IdxMax) && (s1_n2_q == IdxMax);
            s2_n1_q    <= s1_n1_q;
            s2_n2_q    <= s1_n2_q;
            s2_c1_q    <= rom_c1;
            s2_c2_q    <= rom_c2;
        end
    end

    // Truncate the magnitude so the scaled result rounds toward zero for both signs.
    always_comb begin
        prod      = ProdW'(s2_c1_q) * ProdW'(s2_c2_q);
        prod_mag  = prod[ProdW-1] ? -prod : prod;
        term_full = signed'(prod_mag >> FRAC);
        if (prod[ProdW-1]) begin
            term_full = -term_full;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_n1_q    <= '0;
            out_n2_q    <= '0;
            out_term_q  <= '0;
        end else if (advance) begin
            out_valid_q <= s2_valid_q;
            out_last_q  <= s2_last_q;
            out_n1_q    <= s2_n1_q;
            out_n2_q    <= s2_n2_q;
            out_term_q  <= OUT_W'(term_full);
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_n1    = out_n1_q;
    assign out_n2    = out_n2_q;
    assign out_term  = out_term_q;

endmodule
